gcd_job_sequencer: RTL and testbench
====================================

# gcd_job_sequencer

Upstream job front-end for the GCD engine (`gcd_datapath` + `gcd_control`). It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. For each pair it drives the engine's reset/start/data load sequence, waits for `done` and returns the result over a valid/ready output. Zero operands bypass the engine, which never terminates on a zero input.

## Interface
- `WIDTH`, 16, operand/result width; matches engine `data_in`.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 1023, WAIT-state limit; used only with `GCD_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO not full.
- `in_a`, `in_b` in WIDTH: operands.
- `gcd_rst` out 1: one-cycle pulse that returns the engine to S0 and clears its `done`.
- `gcd_start` out 1: engine start.
- `gcd_data` out WIDTH: engine `data_in`.
- `gcd_done` in 1: engine done; sticky until `gcd_rst`.
- `gcd_result` in WIDTH: engine A register value; valid while `gcd_done` is high.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_gcd`, `out_a`, `out_b` out WIDTH: result and echoed operands.
- `out_err` out 1: timeout flag.
- `busy` out 1: FSM not in IDLE.

## Operation
- **FIFO:** entries are {a,b}, tracked with a count register.
  - Push when `in_valid && in_ready`; `in_ready = (count != DEPTH)`.
  - Pop only in IDLE when count is non-zero.
  - A push and pop in the same cycle leaves count unchanged.
- **IDLE:** on pop, latch a and b into job registers.
  - If a==0 or b==0: `out_gcd` = a|b (0 when both are 0), go to OUT. The engine is untouched.
  - Otherwise go to CLR.
- **CLR:** `gcd_rst`=1, `gcd_start`=0. Next state LDA.
- **LDA:** `gcd_data`=a, `gcd_start`=1. The engine loads A and moves S0→S1 on this edge. Next state LDB.
- **LDB:** `gcd_data`=b, `gcd_start`=0. The engine loads B on this edge. Next state WAIT.
- **WAIT:** `gcd_data`=0. Sample `gcd_done` every cycle.
  - When it is 1: capture `gcd_result` into `out_gcd`, set `out_err`=0, go to OUT.
- **OUT:** `out_valid`=1. `out_gcd`, `out_a`, `out_b` and `out_err` hold stable until `out_ready`.
  - On handshake: `out_valid`=0, go to IDLE. No pop happens in that same cycle.
- **Engine outputs outside their states:** `gcd_start`, `gcd_rst` and `gcd_data` are 0.

## Timing
- **Reset values:** all outputs 0 except `in_ready`=1. FIFO is emptied, FSM is in IDLE, job and timeout registers are 0.
- **Reset mid-job:** the job in flight and all queued jobs are discarded. The next accepted job starts with CLR, which re-initialises the engine.
- **Bypass latency:** accept at edge N, pop at N+1, `out_valid` high from N+2.
- **Engine-path latency:** pop at edge P; CLR, LDA and LDB occupy cycles P+1..P+3; WAIT starts at P+4. `out_valid` rises one cycle after the first WAIT cycle that sees `gcd_done`=1.
- **Input side:** `in_ready` depends only on count, never on `in_valid`.
- **Throughput:** at most one job in the engine at a time.
- **Done qualification:** `gcd_done` is ignored outside WAIT.

## Configuration
- **`GCD_SEQ_TIMEOUT_EN` defined:** a counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `gcd_done`: go to OUT with `out_gcd`=0, `out_err`=1.
  - The next job's CLR recovers the engine.
- **Not defined:** no counter exists, WAIT waits indefinitely, and `out_err` is tied to 0.

## Test plan
- **Normal job:** push (48,18) with an engine model returning 6.
  - Required: one `gcd_rst` pulse, then `gcd_start`=1 with `gcd_data`=48, then `gcd_data`=18.
  - Result: `out_gcd`=6, `out_a`=48, `out_b`=18, `out_err`=0.
- **Zero bypass:** push (0,35) and (0,0).
  - Required: `gcd_start` never asserts.
  - Results 35 then 0, each with `out_valid` 2 cycles after the pop-eligible accept.
- **Fill:** engine `done` held low, `out_ready`=1, push 6 pairs back-to-back.
  - Required: 5 accepted (1 in WAIT, 4 queued), then `in_ready`=0.
  - Raise `done` with result 1: `in_ready` returns.
- **Backpressure:** result ready while `out_ready`=0 for 10 cycles.
  - Required: `out_valid`, `out_gcd`, `out_a` and `out_b` stable; exactly one output per job after release.
- **Reset in WAIT with 3 jobs queued:**
  - Required: all outputs 0 and `in_ready`=1 after reset; no stale result.
  - A new push of (21,14) yields 7.
- **Timeout (`GCD_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** `done` withheld.
  - Required: `out_err`=1, `out_gcd`=0 after 16 WAIT cycles.
  - The next job (9,6) runs CLR and returns 3 with `out_err`=0.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// Job front-end for the GCD engine: buffers operand pairs, sequences engine load, returns results.
// Optional WAIT-state timeout is enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_rst,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic             busy
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB, S_WAIT, S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;

  logic [WIDTH-1:0] r_job_a;
  logic [WIDTH-1:0] r_job_b;
  logic [WIDTH-1:0] r_out_gcd;

  logic             w_res_ld;
  logic [WIDTH-1:0] w_res_val;
  logic             w_gcd_rst_nxt;
  logic             w_gcd_start_nxt;
  logic [WIDTH-1:0] w_gcd_data_nxt;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    r_tmo;
  logic             w_tmo_clr;
  logic             w_tmo_inc;
  logic             w_err_val;
  logic             r_out_err;
`else
  logic             w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_a = r_mem_a[r_rd_ptr];
  assign w_head_b = r_mem_b[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Next-state and next-output decode; engine outputs follow the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_res_ld    = 1'b0;
    w_res_val   = '0;
`ifdef GCD_SEQ_TIMEOUT_EN
    w_tmo_clr   = 1'b0;
    w_tmo_inc   = 1'b0;
    w_err_val   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if ((w_head_a == '0) || (w_head_b == '0)) begin
            w_state_nxt = S_OUT;
            w_res_ld    = 1'b1;
            w_res_val   = w_head_a | w_head_b;
          end else begin
            w_state_nxt = S_CLR;
          end
        end
      end
      S_CLR: w_state_nxt = S_LDA;
      S_LDA: w_state_nxt = S_LDB;
      S_LDB: begin
        w_state_nxt = S_WAIT;
`ifdef GCD_SEQ_TIMEOUT_EN
        w_tmo_clr   = 1'b1;
`endif
      end
      S_WAIT: begin
        if (gcd_done) begin
          w_state_nxt = S_OUT;
          w_res_ld    = 1'b1;
          w_res_val   = gcd_result;
        end
`ifdef GCD_SEQ_TIMEOUT_EN
        else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_OUT;
          w_res_ld    = 1'b1;
          w_res_val   = '0;
          w_err_val   = 1'b1;
        end else begin
          w_tmo_inc   = 1'b1;
        end
`endif
      end
      S_OUT: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_gcd_rst_nxt   = (w_state_nxt == S_CLR);
    w_gcd_start_nxt = (w_state_nxt == S_LDA);
    w_gcd_data_nxt  = '0;
    if (w_state_nxt == S_LDA) w_gcd_data_nxt = r_job_a;
    if (w_state_nxt == S_LDB) w_gcd_data_nxt = r_job_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      gcd_rst   <= 1'b0;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      gcd_rst   <= w_gcd_rst_nxt;
      gcd_start <= w_gcd_start_nxt;
      gcd_data  <= w_gcd_data_nxt;
      out_valid <= (w_state_nxt == S_OUT);
      busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job_a   <= '0;
      r_job_b   <= '0;
      r_out_gcd <= '0;
    end else begin
      if (w_pop) begin
        r_job_a <= w_head_a;
        r_job_b <= w_head_b;
      end
      if (w_res_ld) r_out_gcd <= w_res_val;
    end
  end

`ifdef GCD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo     <= '0;
      r_out_err <= 1'b0;
    end else begin
      if (w_tmo_clr)      r_tmo <= '0;
      else if (w_tmo_inc) r_tmo <= r_tmo + TW'(1);
      if (w_res_ld) r_out_err <= w_err_val;
    end
  end
  assign out_err = r_out_err;
`else
  assign out_err = 1'b0;
`endif

  assign out_gcd = r_out_gcd;
  assign out_a   = r_job_a;
  assign out_b   = r_job_b;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural GCD engine model.
module tb_gcd_job_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         gcd_rst, gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done = 1'b0;
  logic [W-1:0] gcd_result = '0;
  logic         out_valid, out_ready;
  logic [W-1:0] out_gcd, out_a, out_b;
  logic         out_err, busy;

  gcd_job_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .gcd_rst(gcd_rst), .gcd_start(gcd_start),
    .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_a(out_a), .out_b(out_b), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Engine model: reset clears it, start loads A, next cycle loads B, done after a random delay.
  logic         hold_done = 1'b0;
  int           e_st = 0;
  int           e_cnt = 0;
  logic [W-1:0] e_a = '0, e_b = '0;
  logic         prev_rst = 1'b0;

  always @(posedge clk) begin
    if (gcd_rst) begin
      e_st = 0;
      gcd_done <= 1'b0;
    end else begin
      case (e_st)
        0: if (gcd_start) begin
             chk("start_after_rst", prev_rst, 1);
             chk("lda_nonzero", (gcd_data != '0), 1);
             e_a  = gcd_data;
             e_st = 1;
           end
        1: begin
             chk("ldb_start_low", gcd_start, 0);
             chk("ldb_nonzero", (gcd_data != '0), 1);
             e_b   = gcd_data;
             e_st  = 2;
             e_cnt = $urandom_range(0, 6);
           end
        2: if (!hold_done) begin
             if (e_cnt == 0) begin
               gcd_done   <= 1'b1;
               gcd_result <= ref_gcd(e_a, e_b);
               e_st = 3;
             end else begin
               e_cnt--;
             end
           end
        default: ;
      endcase
      if (e_st >= 2 && !rst) chk("start_unexpected", gcd_start, 0);
    end
    prev_rst = gcd_rst;
  end

  // Monitor: pops expected results on handshake and checks stability under backpressure.
  logic         held = 1'b0;
  logic [W-1:0] h_g, h_a, h_b;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_gcd", out_gcd, h_g);
        chk("hold_a", out_a, h_a);
        chk("hold_b", out_b, h_b);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e_pop = sb.pop_front();
          chk("out_gcd", out_gcd, e_pop.g);
          chk("out_a", out_a, e_pop.a);
          chk("out_b", out_b, e_pop.b);
          chk("out_err", out_err, e_pop.err);
          if (e_pop.a != '0 && e_pop.b != '0 && !e_pop.err) begin
            chk("eng_load_a", e_a, e_pop.a);
            chk("eng_load_b", e_b, e_pop.b);
          end
        end
      end
      held = out_valid && !out_ready;
      h_g  = out_gcd;
      h_a  = out_a;
      h_b  = out_b;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_e(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] g, input logic err);
    int   tries;
    logic acc;
    tries    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    do begin
      acc = in_ready;
      cyc(1);
      tries++;
    end while (!acc && tries < 200);
    in_valid = 1'b0;
    if (acc) sb.push_back('{g, a, b, err});
    else     chk("push_timeout", acc, 1);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    push_e(a, b, ref_gcd(a, b), 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      cyc(1);
      n++;
    end
    chk("drain", (sb.size() == 0 && !busy), 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gcd_rst", gcd_rst, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_gcd_data", gcd_data, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_err", out_err, 0);
  endtask

  initial begin
    int n;
    int n_acc;
    logic acc;
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    cyc(3);
    chk_reset_outputs();
    rst = 1'b0;
    cyc(1);

    // Normal job under 10 cycles of backpressure.
    push(16'd48, 16'd18);
    n = 0;
    while (!out_valid && n < 100) begin cyc(1); n++; end
    chk("normal_out_valid", out_valid, 1);
    cyc(10);
    drain();

    // Zero bypass with latency check.
    push(16'd0, 16'd35);
    chk("bypass1_lat_n1", out_valid, 0);
    cyc(1);
    chk("bypass1_lat_n2", out_valid, 1);
    drain();
    push(16'd0, 16'd0);
    chk("bypass2_lat_n1", out_valid, 0);
    cyc(1);
    chk("bypass2_lat_n2", out_valid, 1);
    drain();

    // Fill with done withheld.
    hold_done = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc      = in_ready;
      ra       = W'($urandom_range(1, 500));
      rb       = W'($urandom_range(1, 500));
      in_valid = 1'b1; in_a = ra; in_b = rb;
      cyc(1);
      if (acc) begin
        sb.push_back('{ref_gcd(ra, rb), ra, rb, 1'b0});
        n_acc++;
      end
    end
    in_valid = 1'b0;
    chk("fill_accepted", n_acc, 5);
    chk("fill_in_ready_low", in_ready, 0);
    hold_done = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin cyc(1); n++; end
    chk("fill_in_ready_back", in_ready, 1);
    drain();

    // Reset while in WAIT with three jobs queued.
    hold_done = 1'b1;
    push(16'd100, 16'd75);
    push(16'd12, 16'd8);
    push(16'd81, 16'd27);
    push(16'd14, 16'd49);
    cyc(8);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    sb.delete();
    cyc(2);
    rst = 1'b0;
    hold_done = 1'b0;
    cyc(3);
    push(16'd21, 16'd14);
    drain();
    cyc(20);

`ifdef GCD_SEQ_TIMEOUT_EN
    // Timeout with done withheld, then recovery.
    hold_done = 1'b1;
    push_e(16'd5, 16'd10, 16'd0, 1'b1);
    drain();
    hold_done = 1'b0;
    push(16'd9, 16'd6);
    drain();
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        ra  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 65535));
        rb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 2000));
        acc = in_ready;
        in_valid = 1'b1; in_a = ra; in_b = rb;
        cyc(1);
        if (acc) sb.push_back('{ref_gcd(ra, rb), ra, rb, 1'b0});
      end else begin
        in_valid = 1'b0;
        cyc(1);
      end
    end
    in_valid = 1'b0;
    drain();
    cyc(10);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
